// File: rtl/com_sync_fifo_reg_if.sv
// Bundle of the FIFO's write, read and status signals between producer/consumer and the FIFO.
// No logic or latency; it only groups wires.
// Flow control is wr_full and rd_empty; the master side drives requests and the slave side answers.
interface com_sync_fifo_reg_if #(
    parameter int DW = 8,
    parameter int AW = 3
);
    logic          wr_en;
    logic [DW-1:0] wr_data;
    logic          wr_full;
    logic          wr_afull;
    logic          rd_en;
    logic [DW-1:0] rd_data;
    logic          rd_empty;
    logic          rd_aempty;
    logic [AW-1:0] water_level;
    logic          err_ovf;
    logic          err_udf;

    modport master (
        output wr_en, wr_data, rd_en,
        input  wr_full, wr_afull, rd_data, rd_empty, rd_aempty, water_level, err_ovf, err_udf
    );

    modport slave (
        input  wr_en, wr_data, rd_en,
        output wr_full, wr_afull, rd_data, rd_empty, rd_aempty, water_level, err_ovf, err_udf
    );
endinterface

// File: rtl/com_sync_fifo_reg.sv
// Single-clock FIFO with a registered first-word-fall-through head; optional sticky error checker under COM_SYNC_FIFO_ERR_CHK_EN.
// Latency: a write into an empty FIFO is visible on rd_data two edges later; streaming runs at one word per cycle.
// Backpressure: writes are dropped while wr_full (memory full); reads on rd_empty are ignored.
module com_sync_fifo_reg #(
    parameter int DW        = 8,
    parameter int DEPTH     = 4,
    parameter int AW        = $clog2(DEPTH + 2),
    parameter int AFULL_TH  = DEPTH,
    parameter int AEMPTY_TH = 1
) (
    input  logic                clk,
    input  logic                rst,
    input  logic                clear,
    com_sync_fifo_reg_if.slave  bus
);
    localparam int PW = $clog2(DEPTH);
    localparam int CW = $clog2(DEPTH + 1);
    localparam logic [AW-1:0] AFULL_LVL  = AW'(AFULL_TH);
    localparam logic [AW-1:0] AEMPTY_LVL = AW'(AEMPTY_TH);

    logic [DW-1:0] mem [DEPTH];
    logic [PW-1:0] wr_ptr;
    logic [PW-1:0] rd_ptr;
    logic [CW-1:0] mem_cnt;
    logic          out_flag;
    logic [DW-1:0] out_data;

    logic          full;
    logic          accept;
    logic          pull;
    logic          pop;
    logic [AW-1:0] level;

    // Full is taken from registers only, so a pull in the same cycle never frees a slot for a write.
    assign full   = (mem_cnt == CW'(DEPTH));
    assign accept = bus.wr_en && !full;
    assign pull   = (mem_cnt != '0) && (!out_flag || bus.rd_en);
    assign pop    = bus.rd_en && out_flag && !pull;
    assign level  = AW'(mem_cnt) + AW'(out_flag);

    // Storage array, no reset; writes are suppressed while rst or clear is active.
    always_ff @(posedge clk) begin
        if (!rst && !clear && accept) begin
            mem[wr_ptr] <= bus.wr_data;
        end
    end

    // Pointers and occupancy of the memory part; both pointers wrap at DEPTH-1 for non-power-of-two depths.
    always_ff @(posedge clk) begin
        if (rst || clear) begin
            wr_ptr  <= '0;
            rd_ptr  <= '0;
            mem_cnt <= '0;
        end else begin
            if (accept) begin
                wr_ptr <= (wr_ptr == PW'(DEPTH - 1)) ? '0 : wr_ptr + PW'(1);
            end
            if (pull) begin
                rd_ptr <= (rd_ptr == PW'(DEPTH - 1)) ? '0 : rd_ptr + PW'(1);
            end
            if (accept && !pull) begin
                mem_cnt <= mem_cnt + CW'(1);
            end else if (pull && !accept) begin
                mem_cnt <= mem_cnt - CW'(1);
            end
        end
    end

    // Output register: refilled from memory whenever it is empty or being consumed; data holds across clear.
    always_ff @(posedge clk) begin
        if (rst) begin
            out_flag <= 1'b0;
            out_data <= '0;
        end else if (clear) begin
            out_flag <= 1'b0;
        end else if (pull) begin
            out_flag <= 1'b1;
            out_data <= mem[rd_ptr];
        end else if (pop) begin
            out_flag <= 1'b0;
        end
    end

`ifdef COM_SYNC_FIFO_ERR_CHK_EN
    logic ovf_q;
    logic udf_q;

    // Sticky protocol-error flags, cleared only by rst or clear.
    always_ff @(posedge clk) begin
        if (rst || clear) begin
            ovf_q <= 1'b0;
            udf_q <= 1'b0;
        end else begin
            if (bus.wr_en && full) begin
                ovf_q <= 1'b1;
            end
            if (bus.rd_en && !out_flag) begin
                udf_q <= 1'b1;
            end
        end
    end

    assign bus.err_ovf = ovf_q;
    assign bus.err_udf = udf_q;
`else
    assign bus.err_ovf = 1'b0;
    assign bus.err_udf = 1'b0;
`endif

    assign bus.wr_full     = full;
    assign bus.wr_afull    = (level >= AFULL_LVL);
    assign bus.rd_aempty   = (level <= AEMPTY_LVL);
    assign bus.rd_empty    = !out_flag;
    assign bus.rd_data     = out_data;
    assign bus.water_level = level;
endmodule

// File: tb/tb_com_sync_fifo_reg.sv
// Self-checking bench: queue-based reference model compared every cycle, plus literal spot checks.
// Directed scenarios (reset, single word, fill/overflow, streaming, wrap, clear) followed by a random phase.
// Inputs change 1 time unit after the rising edge; the compare process samples on the falling edge.
module tb_com_sync_fifo_reg;
    localparam int DW        = 8;
    localparam int DEPTH     = 4;
    localparam int AW        = $clog2(DEPTH + 2);
    localparam int AFULL_TH  = 4;
    localparam int AEMPTY_TH = 1;

    logic clk = 1'b0;
    logic rst = 1'b1;
    logic clear = 1'b0;

    com_sync_fifo_reg_if #(.DW(DW), .AW(AW)) ifc ();

    com_sync_fifo_reg #(
        .DW(DW), .DEPTH(DEPTH), .AW(AW), .AFULL_TH(AFULL_TH), .AEMPTY_TH(AEMPTY_TH)
    ) dut (
        .clk   (clk),
        .rst   (rst),
        .clear (clear),
        .bus   (ifc)
    );

    always #5 clk = ~clk;

    int n_chk  = 0;
    int n_pass = 0;

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_chk++;
        if (act === exp) n_pass++;
        else $display("FAIL %s: got 0x%0h, expected 0x%0h at %0t", name, act, exp, $time);
    endtask

    // Reference model: every held word in one queue; 'vis' says whether the head is already presented.
    logic [DW-1:0] q[$];
    bit            vis = 0;
    logic [DW-1:0] rdv = '0;
    bit            m_ovf = 0;
    bit            m_udf = 0;
    bit            armed = 0;
    int            stored;
    bit            m_full;
    bit            nvis;

    always @(posedge clk) begin
        armed = 1;
        if (rst) begin
            q.delete(); vis = 0; rdv = '0; m_ovf = 0; m_udf = 0;
        end else if (clear) begin
            q.delete(); vis = 0; m_ovf = 0; m_udf = 0;
        end else begin
            stored = q.size() - int'(vis);
            m_full = (stored == DEPTH);
`ifdef COM_SYNC_FIFO_ERR_CHK_EN
            if (ifc.wr_en && m_full) m_ovf = 1;
            if (ifc.rd_en && !vis)   m_udf = 1;
`endif
            // Head is shown next cycle if a word was waiting behind it, or it stays unconsumed.
            nvis = (stored > 0) || (vis && !ifc.rd_en);
            if (ifc.rd_en && vis) void'(q.pop_front());
            if (ifc.wr_en && !m_full) q.push_back(ifc.wr_data);
            vis = nvis;
            if (vis) rdv = q[0];
        end
    end

    // Per-cycle comparison of every output against the model.
    always @(negedge clk) begin
        if (armed) begin
            chk("water_level", 32'(ifc.water_level), 32'(q.size()));
            chk("rd_empty",    32'(ifc.rd_empty),    32'(!vis));
            chk("rd_data",     32'(ifc.rd_data),     32'(rdv));
            chk("wr_full",     32'(ifc.wr_full),     32'((q.size() - int'(vis)) == DEPTH));
            chk("wr_afull",    32'(ifc.wr_afull),    32'(q.size() >= AFULL_TH));
            chk("rd_aempty",   32'(ifc.rd_aempty),   32'(q.size() <= AEMPTY_TH));
            chk("err_ovf",     32'(ifc.err_ovf),     32'(m_ovf));
            chk("err_udf",     32'(ifc.err_udf),     32'(m_udf));
        end
    end

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    task automatic drive(input bit we, input logic [DW-1:0] wd, input bit re);
        ifc.wr_en   = we;
        ifc.wr_data = wd;
        ifc.rd_en   = re;
    endtask

    bit exp_err;

    initial begin
`ifdef COM_SYNC_FIFO_ERR_CHK_EN
        exp_err = 1;
`else
        exp_err = 0;
`endif
        drive(0, '0, 0);
        step(); step();
        chk("rst_empty", 32'(ifc.rd_empty), 32'd1);
        chk("rst_data",  32'(ifc.rd_data),  32'h00);
        chk("rst_level", 32'(ifc.water_level), 32'd0);
        chk("rst_aempty", 32'(ifc.rd_aempty), 32'd1);
        rst = 1'b0;

        // Single word
        drive(1, 8'hA5, 0); step();
        drive(0, '0, 0);
        chk("single_level_n", 32'(ifc.water_level), 32'd1);
        chk("single_empty_n", 32'(ifc.rd_empty), 32'd1);
        step();
        chk("single_empty_n1", 32'(ifc.rd_empty), 32'd0);
        chk("single_data_n1",  32'(ifc.rd_data), 32'hA5);
        drive(0, '0, 1); step();
        drive(0, '0, 0);
        chk("single_pop_empty", 32'(ifc.rd_empty), 32'd1);
        chk("single_pop_level", 32'(ifc.water_level), 32'd0);

        // Fill and overflow
        for (int i = 1; i <= 6; i++) begin
            drive(1, 8'(i), 0); step();
            if (i == 3) chk("fill_afull3", 32'(ifc.wr_afull), 32'd0);
            if (i == 4) chk("fill_afull4", 32'(ifc.wr_afull), 32'd1);
            if (i == 5) chk("fill_full5", 32'(ifc.wr_full), 32'd1);
        end
        drive(0, '0, 0);
        chk("fill_level", 32'(ifc.water_level), 32'd5);
        chk("fill_ovf", 32'(ifc.err_ovf), 32'(exp_err));
        for (int i = 1; i <= 5; i++) begin
            chk("drain_data", 32'(ifc.rd_data), 32'(i));
            drive(0, '0, 1); step();
        end
        drive(0, '0, 0);
        chk("drain_empty", 32'(ifc.rd_empty), 32'd1);

        // Streaming at constant level 3
        for (int i = 0; i < 3; i++) begin
            drive(1, 8'(8'h40 + i), 0); step();
        end
        for (int i = 0; i < 20; i++) begin
            chk("stream_level", 32'(ifc.water_level), 32'd3);
            chk("stream_data",  32'(ifc.rd_data), 32'(8'h40 + i));
            drive(1, 8'(8'h43 + i), 1); step();
        end
        for (int i = 0; i < 3; i++) begin
            drive(0, '0, 1); step();
        end
        drive(0, '0, 0);
        chk("stream_empty", 32'(ifc.rd_empty), 32'd1);

        // Pointer wrap over three rounds
        for (int r = 0; r < 3; r++) begin
            for (int i = 0; i < 4; i++) begin
                drive(1, 8'(8'h80 + r * 16 + i), 0); step();
            end
            for (int i = 0; i < 4; i++) begin
                drive(0, '0, 0);
                if (i == 0) step();
                chk("wrap_data", 32'(ifc.rd_data), 32'(8'h80 + r * 16 + i));
                drive(0, '0, 1); step();
            end
            drive(0, '0, 0);
        end
        chk("wrap_empty", 32'(ifc.rd_empty), 32'd1);

        // Clear with a concurrent write
        for (int i = 0; i < 3; i++) begin
            drive(1, 8'(8'h21 + i), 0); step();
        end
        clear = 1'b1; drive(1, 8'h77, 0); step();
        clear = 1'b0; drive(0, '0, 0);
        chk("clear_empty", 32'(ifc.rd_empty), 32'd1);
        chk("clear_level", 32'(ifc.water_level), 32'd0);
        drive(0, '0, 1); step();
        drive(0, '0, 0);
        chk("clear_udf", 32'(ifc.err_udf), 32'(exp_err));
        drive(1, 8'h10, 0); step();
        drive(0, '0, 0); step();
        chk("clear_readback", 32'(ifc.rd_data), 32'h10);
        chk("clear_level1", 32'(ifc.water_level), 32'd1);
        clear = 1'b1; step();
        clear = 1'b0;
        chk("clear_udf_reset", 32'(ifc.err_udf), 32'd0);

        // Random traffic with occasional clear/reset
        for (int i = 0; i < 3000; i++) begin
            drive(bit'($urandom_range(0, 99) < 55), 8'($urandom), bit'($urandom_range(0, 99) < 50));
            clear = ($urandom_range(0, 99) == 0);
            rst   = ($urandom_range(0, 299) == 0);
            step();
        end
        rst = 1'b0; clear = 1'b0; drive(0, '0, 0);
        step();

        $display("%0d/%0d checks passed", n_pass, n_chk);
        $finish;
    end
endmodule
